mult_accum: RTL
===============

# mult_accum

Frame accumulator directly downstream of `optmult`. It consumes the registered product stream, sign- or zero-extends each product and adds it into a saturating accumulator. Every `FRAME_LEN` valid products it emits the frame sum through a 2-entry output FIFO with a valid/ready handshake. The multiplier pipeline cannot stall, so this block never back-pressures its input; a frame that completes while the FIFO is full is dropped and flagged.

## Interface

Parameters:

- `P_W`, default 16: product width, equal to `M_W+N_W` of the feeding `optmult`.
- `ACC_W`, default 24: accumulator and result width; must be ≥ `P_W`.
- `FRAME_LEN`, default 16: number of valid products per frame; must be ≥ 2.
- `UNSIGNED`, default 0: 1 zero-extends products and uses the unsigned clamp; 0 sign-extends and uses the signed clamp.

Ports:

- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_prod` is a valid product this cycle.
- `in_prod`, input, `P_W`: product from `optmult.out`.
- `in_clear`, input, 1: discard the partial frame.
- `out_valid`, output, 1: FIFO head holds a frame result.
- `out_ready`, input, 1: consumer accepts the head when `out_valid` is also high.
- `out_sum`, output, `ACC_W`: frame sum at the FIFO head.
- `out_sat`, output, 1: the head frame saturated at least once.
- `overrun`, output, 1: one-cycle pulse when a completed frame was dropped.

## Operation

- State machine:
  - IDLE: count == 0, acc == 0.
  - ACCUM: 0 < count < `FRAME_LEN`.
  - IDLE→ACCUM on a valid sample when `FRAME_LEN` > 1.
  - ACCUM→IDLE on the `FRAME_LEN`-th valid sample, or on `in_clear` without `in_valid`.
- Per valid sample:
  - ext = `in_prod` extended to `ACC_W`+1 bits.
  - sum = acc + ext, computed at `ACC_W`+2 bits.
  - Signed clamp range is [−2^(`ACC_W`−1), 2^(`ACC_W`−1)−1]; unsigned clamp range is [0, 2^`ACC_W`−1].
  - If clamping occurs, set the per-frame sticky sat bit.
- Frame completion (valid sample with count == `FRAME_LEN`−1):
  - The clamped sum and sticky sat (including this sample) are pushed to the FIFO.
  - acc, count and sat are cleared in the same edge. The next valid sample starts a new frame.
- `in_clear`:
  - Without `in_valid`: acc, count and sat are cleared.
  - With `in_valid`: the sample is the first of a new frame (acc = clamp(ext), count = 1).
  - Never completes a frame and never touches the FIFO.
- FIFO:
  - 2 entries, each {sum, sat}. Pop when `out_valid && out_ready`. Head order is oldest first.
  - Push while full is allowed only if a pop happens in the same cycle.
  - If full with no pop, the frame is dropped and `overrun` = 1 for the next cycle only. FIFO contents are unchanged. acc still restarts.
  - Simultaneous push and pop when not full: occupancy is unchanged and the order is preserved.
- Products with `in_valid` = 0 are ignored regardless of value.

## Timing

- Reset values:
  - `out_valid` = 0, `out_sum` = 0, `out_sat` = 0, `overrun` = 0.
  - acc = 0, count = 0, FIFO empty.
  - Reset asserted mid-frame or with a non-empty FIFO flushes everything; outputs reach reset values at the first edge with `rst` high.
  - `rst` has priority over all other inputs.
- Latency: the last sample is captured at edge N; `out_valid` = 1 with the frame result from the cycle after edge N (registered FIFO head, no combinational path from `in_*` to `out_*`).
- Throughput: one sample per cycle sustained. Back-to-back frames need no idle cycle.
- `out_sum`/`out_sat` hold stable while `out_valid && !out_ready`.
- `overrun` is registered and high for exactly one cycle per dropped frame.

## Test plan

Unless stated otherwise: `P_W`=16, `ACC_W`=24, `FRAME_LEN`=4, `UNSIGNED`=0, `out_ready`=1.

- Products 3, −5, 7, 10 on four consecutive cycles → one cycle after the 4th: `out_valid`=1 for one cycle, `out_sum`=15, `out_sat`=0.
- Same four products with `in_valid` low for 2 cycles between each, and garbage on `in_prod` during the gaps → `out_sum`=15.
- `ACC_W`=17, products 0x7FFF ×4 → `out_sum`=65535, `out_sat`=1. Repeat with 0x8000 ×4 → `out_sum`=−65536, `out_sat`=1.
- `out_ready`=0, 12 samples of value 1:
  - Three frames complete.
  - The first two sit in the FIFO with `out_valid`=1, `out_sum`=4.
  - The 3rd frame pulses `overrun` for 1 cycle.
  - Raising `out_ready` → two pops of 4, then `out_valid`=0.
- Samples 100, 200; then 1 with `in_clear`=1; then 2, 3, 4 → `out_sum`=10 (the 300 is discarded).
- 2 samples into a frame with 1 result queued, assert `rst` → next cycle `out_valid`=0; a fresh 1, 1, 1, 1 → `out_sum`=4.

Source files
------------

// File: rtl/mult_accum.sv
// Frame accumulator behind optmult: saturating sum of FRAME_LEN valid products, queued in a 2-entry FIFO.
// Result is visible one cycle after the last sample; the input never stalls, and a frame that meets a full FIFO is dropped (overrun).
module mult_accum_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             vld_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign vld_o   = (cnt_q != '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && vld_o;
  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

module mult_accum #(
  parameter int P_W       = 16,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int UNSIGNED  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [P_W-1:0]   in_prod,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             overrun
);
  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base, clamped;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             sat_q, sat_d, sat_base, clip, fresh, done;
  logic [SW-1:0]    acc_x, ext_x, sum_x;
  logic [2:0]       top3;
  logic             push, pop, full, overrun_q;
  logic [ACC_W:0]   head;

  // in_clear with a valid sample makes that sample the first of a new frame
  assign fresh    = in_clear || (state_q == IDLE);
  assign acc_base = fresh ? '0 : acc_q;
  assign cnt_base = fresh ? '0 : cnt_q;
  assign sat_base = fresh ? 1'b0 : sat_q;
  assign done     = in_valid && (cnt_base == LAST);

  assign acc_x = (UNSIGNED != 0) ? {2'b00, acc_base} : {{2{acc_base[ACC_W-1]}}, acc_base};
  assign ext_x = (UNSIGNED != 0) ? {{(SW-P_W){1'b0}}, in_prod}
                                 : {{(SW-P_W){in_prod[P_W-1]}}, in_prod};
  assign sum_x = acc_x + ext_x;
  assign top3  = sum_x[SW-1:ACC_W-1];

  always_comb begin
    clamped = sum_x[ACC_W-1:0];
    clip    = 1'b0;
    if (UNSIGNED != 0) begin
      if (top3[2:1] != 2'b00) begin
        clip    = 1'b1;
        clamped = '1;
      end
    end else if (top3 != 3'b000 && top3 != 3'b111) begin
      clip    = 1'b1;
      clamped = top3[2] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    push    = 1'b0;
    if (done) begin
      push    = 1'b1;
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (in_valid) begin
      state_d = ACCUM;
      acc_d   = clamped;
      cnt_d   = cnt_base + CNT_W'(1);
      sat_d   = sat_base | clip;
    end else if (in_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      overrun_q <= push && full && !pop;
    end
  end

  assign pop = out_valid && out_ready;

  mult_accum_fifo #(.WIDTH(ACC_W + 1), .DEPTH(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push_i(push),
    .din_i ({sat_base | clip, clamped}),
    .pop_i (pop),
    .head_o(head),
    .vld_o (out_valid),
    .full_o(full)
  );

  assign out_sum = head[ACC_W-1:0];
  assign out_sat = head[ACC_W];
  assign overrun = overrun_q;
endmodule
